// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and constants for the divider-sharing arbiter
package div_share_pkg;
   localparam int DIV_W   = 32;
   localparam int TMO_DEF = 40;
   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
endpackage

// File: rtl/div_share_arbiter_rr_grant.sv
// rr_grant: one-hot round-robin grant, searching upward from the slot after last
module rr_grant #(
   parameter int NREQ = 4,
   localparam int LW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   output logic [NREQ-1:0] gnt
);
   logic [NREQ-1:0] rot, rgnt;
   int s;
   // rotate so the slot after last sits at bit 0, pick lowest set bit, rotate back
   assign s    = int'(last) + 1;
   assign rot  = NREQ'({req, req} >> s);
   assign rgnt = rot & (~rot + NREQ'(1));
   assign gnt  = NREQ'(({rgnt, rgnt} << s) >> NREQ);
endmodule

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one divider with divide-by-zero bypass and done timeout
module div_share_arbiter
   import div_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int TMO  = TMO_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [DIV_W*NREQ-1:0] req_dividend,
   input  logic [DIV_W*NREQ-1:0] req_divisor,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       resp_valid,
   output logic [DIV_W-1:0]      resp_quotient,
   output logic [DIV_W-1:0]      resp_remainder,
   output logic                  resp_dbz,
   output logic                  resp_err,
   output logic                  busy,
   output logic                  div_start,
   output logic [DIV_W-1:0]      div_dividend,
   output logic [DIV_W-1:0]      div_divisor,
   input  logic                  div_done,
   input  logic [DIV_W-1:0]      div_quotient,
   input  logic [DIV_W-1:0]      div_remainder
);
   localparam int LW = $clog2(NREQ);
   localparam int CW = $clog2(TMO + 1);
   state_t state, nxt;
   logic [NREQ-1:0] gnt;
   logic [LW-1:0] last, win_idx;
   logic [DIV_W-1:0] win_dvd, win_dvs;
   logic [CW-1:0] cnt;
   logic xfer, dbz_go, done_go, tmo_go;
   rr_grant #(.NREQ(NREQ)) u_rr (.req(req_valid), .last(last), .gnt(gnt));
   always_comb begin
      win_idx = '0;
      win_dvd = '0;
      win_dvs = '0;
      for (int i = 0; i < NREQ; i++)
         if (gnt[i]) begin
            win_idx = LW'(i);
            win_dvd = req_dividend[i*DIV_W +: DIV_W];
            win_dvs = req_divisor[i*DIV_W +: DIV_W];
         end
   end
   assign xfer    = state == IDLE && |gnt;
   assign dbz_go  = xfer && win_dvs == '0;
   assign done_go = state == RUN && div_done;
   assign tmo_go  = state == RUN && !div_done && cnt == CW'(TMO - 1);
   always_comb begin
      nxt        = state == IDLE ? (xfer ? (dbz_go ? RESP : RUN) : IDLE)
                 : state == RUN  ? ((done_go || tmo_go) ? RESP : RUN) : IDLE;
      req_ready  = (state == IDLE && rst_n) ? gnt : '0;
      resp_valid = state == RESP ? NREQ'(1) << last : '0;
      busy       = state != IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   // last doubles as the in-flight requester index; it only changes on a transfer
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last           <= LW'(NREQ - 1);
         cnt            <= '0;
         div_start      <= 1'b0;
         div_dividend   <= '0;
         div_divisor    <= '0;
         resp_quotient  <= '0;
         resp_remainder <= '0;
         resp_dbz       <= 1'b0;
         resp_err       <= 1'b0;
      end else begin
         div_start <= nxt == RUN;
         cnt       <= state == RUN ? cnt + CW'(1) : '0;
         if (xfer) begin
            last         <= win_idx;
            div_dividend <= win_dvd;
            div_divisor  <= win_dvs;
         end
         if (dbz_go || done_go || tmo_go) begin
            resp_quotient  <= dbz_go ? '1 : done_go ? div_quotient : '0;
            resp_remainder <= dbz_go ? win_dvd : done_go ? div_remainder : '0;
            resp_dbz       <= dbz_go;
            resp_err       <= tmo_go;
         end
      end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed and random checks against a behavioural arbitration/divide model
module tb_div_share_arbiter;
   localparam int N = 4, TMO = 40, DLAT = 35;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] req_valid = '0;
   logic [32*N-1:0] req_dividend, req_divisor;
   logic [N-1:0] req_ready, resp_valid;
   logic [31:0] resp_quotient, resp_remainder, div_dividend, div_divisor, div_quotient, div_remainder;
   logic resp_dbz, resp_err, busy, div_start, div_done;
   logic done_en = 1, done_force = 0, flag;
   int a [N], b [N];
   int cyc = 0, dcnt = 0, last = N - 1, errors = 0, checks = 0;

   div_share_arbiter #(.NREQ(N), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dividend(req_dividend),
      .req_divisor(req_divisor), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_quotient(resp_quotient), .resp_remainder(resp_remainder), .resp_dbz(resp_dbz),
      .resp_err(resp_err), .busy(busy), .div_start(div_start), .div_dividend(div_dividend),
      .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient),
      .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // divider model: done in the DLAT-th consecutive cycle of div_start
   always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;
   assign div_done      = done_force | (done_en && div_start && dcnt == DLAT - 1);
   assign div_quotient  = div_divisor == 0 ? 32'h0 : 32'($signed(div_dividend) / $signed(div_divisor));
   assign div_remainder = div_divisor == 0 ? 32'h0 : 32'($signed(div_dividend) % $signed(div_divisor));
   always_comb
      for (int k = 0; k < N; k++) begin
         req_dividend[k*32 +: 32] = a[k];
         req_divisor[k*32 +: 32]  = b[k];
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input logic [N-1:0] v, input int l);
      for (int i = 1; i <= N; i++) if (v[(l + i) % N]) return (l + i) % N;
      return 0;
   endfunction

   // called at the negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle
   task automatic run_one();
      int ek, t, elat;
      logic got = 0, saw_start = 0, bad = 0;
      logic [31:0] eq, er;
      #1;
      ek   = winner(req_valid, last);
      elat = b[ek] == 0 ? 1 : done_en ? DLAT + 1 : TMO + 1;
      eq   = b[ek] == 0 ? 32'hFFFF_FFFF : done_en ? 32'(a[ek] / b[ek]) : 32'h0;
      er   = b[ek] == 0 ? 32'(a[ek]) : done_en ? 32'(a[ek] % b[ek]) : 32'h0;
      chk("ready_grant", 32'(req_ready), 32'(1) << ek);
      chk("busy_idle", 32'(busy), 32'h0);
      t = cyc;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         saw_start |= div_start;
         bad |= (|req_ready) | !busy;
         got = |resp_valid;
      end
      chk("resp_seen", 32'(got), 32'h1);
      chk("latency", 32'(cyc - t), 32'(elat));
      chk("resp_onehot", 32'(resp_valid), 32'(1) << ek);
      chk("quotient", resp_quotient, eq);
      chk("remainder", resp_remainder, er);
      chk("dbz", 32'(resp_dbz), 32'(b[ek] == 0));
      chk("err", 32'(resp_err), 32'(b[ek] != 0 && !done_en));
      chk("ready_busy_run", 32'(bad), 32'h0);
      chk("div_start_seen", 32'(saw_start), 32'(b[ek] != 0));
      @(negedge clk);
      chk("resp_one_cycle", 32'(resp_valid), 32'h0);
      chk("hold_quotient", resp_quotient, eq);
      last = ek;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      a = '{100, -100, 55, 12345};
      b = '{7, 7, 0, -100};
      req_valid = '1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_start", 32'(div_start), 32'h0);
      chk("rst_resp", 32'(resp_valid), 32'h0);
      chk("rst_quot", resp_quotient, 32'h0);
      chk("rst_dvd", div_dividend, 32'h0);
      rst_n = 1;
      repeat (5) run_one();
      req_valid  = '0;
      done_force = 1;
      flag       = 0;
      repeat (3) begin
         @(negedge clk);
         flag |= busy | (|resp_valid);
      end
      done_force = 0;
      chk("spurious_done", 32'(flag), 32'h0);
      done_en   = 0;
      req_valid = 4'b0010;
      a[1] = 999;
      b[1] = 5;
      run_one();
      done_en = 1;
      run_one();
      req_valid = 4'b0100;
      #1 chk("ready_pre_drop", 32'(req_ready), 32'h4);
      req_valid = 4'b1000;
      run_one();
      req_valid = 4'b0001;
      a[0] = 5000;
      b[0] = 3;
      repeat (10) @(negedge clk);
      chk("run10_start", 32'(div_start), 32'h1);
      #1 rst_n = 0;
      #1;
      chk("rst_run_start", 32'(div_start), 32'h0);
      chk("rst_run_busy", 32'(busy), 32'h0);
      chk("rst_run_resp", 32'(resp_valid), 32'h0);
      req_valid = 4'b0101;
      last = N - 1;
      @(negedge clk);
      rst_n = 1;
      run_one();
      for (int n = 0; n < 12; n++) begin
         req_valid = N'($urandom_range(1, 15));
         done_en   = $urandom_range(0, 4) != 0;
         for (int k = 0; k < N; k++) begin
            a[k] = int'($urandom_range(0, 2000000)) - 1000000;
            b[k] = $urandom_range(0, 4) == 0 ? 0 : int'($urandom_range(1, 300)) * ($urandom_range(0, 1) == 1 ? 1 : -1);
         end
         run_one();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
